skid_fallthrough_lat: RTL and testbench

//  Turns a registered-read FIFO (pop -> data after READ_LATENCY cycles) into a

---
 rtl/skid_fallthrough_lat_pkg.sv | 14 +
 rtl/skid_fallthrough_lat_queue.sv | 63 ++++++
 rtl/skid_fallthrough_lat.sv | 111 +++++++++++
 tb/tb_skid_fallthrough_lat.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skid_fallthrough_lat_pkg.sv
// Shared helpers for the skid_fallthrough_lat family: counter and pointer widths.
package skid_fallthrough_lat_pkg;

  // Level/credit counters must hold values up to depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 2);
  endfunction

  // Queue pointer width; a single-entry queue still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/skid_fallthrough_lat_queue.sv
// Circular skid queue. The head is visible combinationally so the output
// register can load it in the same cycle it is popped. Pop while empty is
// ignored; push while full is only accepted together with a pop.
module skid_fallthrough_lat_queue
  import skid_fallthrough_lat_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int CNT_W     = cnt_width(DEPTH),
  localparam int PTR_W     = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_full;
  logic                  w_do_pop;
  logic                  w_do_push;
  logic [PTR_W-1:0]      w_wr_ptr_inc;
  logic [PTR_W-1:0]      w_rd_ptr_inc;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & (~w_full | w_do_pop);
  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Pointer increments with wrap at DEPTH-1 (depth need not be a power of two).
  always_comb begin
    w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    w_rd_ptr_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
  end

  // Storage write; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_do_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/skid_fallthrough_lat.sv
// Adapts a registered-read FIFO with READ_LATENCY cycles of read delay to a
// valid/ready stream with a registered output. Pops are issued against credits
// so every in-flight word always has a reserved queue slot.
module skid_fallthrough_lat
  import skid_fallthrough_lat_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int SKID_DEPTH   = READ_LATENCY + 1,
  localparam int CNT_W       = cnt_width(SKID_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] dn_bus,
  output logic                  dn_val,
  input  logic                  dn_rdy,
  output logic [CNT_W-1:0]      level
);

  logic [READ_LATENCY-1:0] r_inflight;
  logic [CNT_W-1:0]        r_inflight_cnt;
  logic [DATA_WIDTH-1:0]   r_dn_bus;
  logic                    r_dn_val;
  logic [CNT_W-1:0]        r_level;

  logic                    w_arrival;
  logic [CNT_W-1:0]        w_credit;
  logic                    w_out_free;
  logic                    w_q_push;
  logic                    w_q_pop;
  logic                    w_q_nonempty;
  logic [DATA_WIDTH-1:0]   w_q_head;
  logic [CNT_W-1:0]        w_q_cnt;
  logic                    w_dn_val_next;
  logic [CNT_W-1:0]        w_inflight_next;
  logic [CNT_W-1:0]        w_q_cnt_next;

  assign w_arrival    = r_inflight[READ_LATENCY-1];
  assign w_q_nonempty = (w_q_cnt != '0);

  // Credits come from registers only, so dn_rdy never reaches fifo_pop.
  assign w_credit = CNT_W'(SKID_DEPTH) - r_inflight_cnt - w_q_cnt;
  assign fifo_pop = ~rst & ~fifo_empty & (w_credit != '0);

  // Output takes the queue head first (order), else the arrival bypasses the queue.
  always_comb begin
    w_out_free      = ~r_dn_val | dn_rdy;
    w_q_pop         = w_out_free & w_q_nonempty;
    w_q_push        = w_arrival & ~(w_out_free & ~w_q_nonempty);
    w_dn_val_next   = w_out_free ? (w_q_nonempty | w_arrival) : r_dn_val;
    w_inflight_next = r_inflight_cnt + CNT_W'(fifo_pop) - CNT_W'(w_arrival);
    w_q_cnt_next    = w_q_cnt + CNT_W'(w_q_push) - CNT_W'(w_q_pop);
  end

  skid_fallthrough_lat_queue #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (w_q_push),
    .push_data (fifo_data),
    .pop       (w_q_pop),
    .head_data (w_q_head),
    .count     (w_q_cnt)
  );

  // Pop-strobe delay line and its population count; the tail marks arrival.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight     <= '0;
      r_inflight_cnt <= '0;
    end else begin
      r_inflight[0] <= fifo_pop;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end
      r_inflight_cnt <= w_inflight_next;
    end
  end

  // Output data register; held whenever the downstream stalls a valid word.
  always_ff @(posedge clk) begin
    if (w_out_free) begin
      if (w_q_nonempty) begin
        r_dn_bus <= w_q_head;
      end else if (w_arrival) begin
        r_dn_bus <= fifo_data;
      end
    end
  end

  // Output valid and registered occupancy (in-flight + queued + output).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dn_val <= 1'b0;
      r_level  <= '0;
    end else begin
      r_dn_val <= w_dn_val_next;
      r_level  <= w_inflight_next + w_q_cnt_next + CNT_W'(w_dn_val_next);
    end
  end

  assign dn_bus = r_dn_bus;
  assign dn_val = r_dn_val;
  assign level  = r_level;

endmodule

// File: tb/tb_skid_fallthrough_lat.sv
// Directed bench for skid_fallthrough_lat: four instances with different
// latency/depth, each fed by a small registered-read FIFO model.
module tb_skid_fallthrough_lat;
  import skid_fallthrough_lat_pkg::*;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] mem_a [NI][256];
  int          wr_a  [NI];
  logic        gap_a [NI];
  logic        rdy_a [NI];
  logic [31:0] bus_a [NI];
  logic        val_a [NI];
  logic        pop_a [NI];
  logic        empty_a [NI];
  logic [7:0]  lvl_a [NI];

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Instance 0: L=3 D=4; 1: L=1 D=2; 2: L=2 D=3; 3: L=5 D=6.
  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int L  = (gi == 0) ? 3 : (gi == 1) ? 1 : (gi == 2) ? 2 : 5;
    localparam int D  = (gi == 0) ? 4 : L + 1;
    localparam int CW = cnt_width(D);

    int          rd;
    logic [31:0] stg [L];
    logic        pop;
    logic        empty;
    logic        val;
    logic [31:0] bus;
    logic [CW-1:0] lvl;

    assign empty = gap_a[gi] || (rd >= wr_a[gi]);

    // FIFO model: read pointer plus an L-stage read-data pipe.
    always @(posedge clk) begin
      if (rst) rd <= 0;
      else if (pop) rd <= rd + 1;
      stg[0] <= pop ? mem_a[gi][rd[7:0]] : 32'hDEADBEEF;
      for (int k = 1; k < L; k++) stg[k] <= stg[k-1];
    end

    skid_fallthrough_lat #(
      .DATA_WIDTH   (32),
      .READ_LATENCY (L),
      .SKID_DEPTH   (D)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_data  (stg[L-1]),
      .fifo_empty (empty),
      .fifo_pop   (pop),
      .dn_bus     (bus),
      .dn_val     (val),
      .dn_rdy     (rdy_a[gi]),
      .level      (lvl)
    );

    assign pop_a[gi]   = pop;
    assign empty_a[gi] = empty;
    assign val_a[gi]   = val;
    assign bus_a[gi]   = bus;
    assign lvl_a[gi]   = 8'(lvl);
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      wr_a[i]  = 0;
      gap_a[i] = 1'b0;
      rdy_a[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic load(input int i, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      mem_a[i][wr_a[i]] = 32'(base + k);
      wr_a[i] = wr_a[i] + 1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    load(0, 2, 0);
    #1;
    cmp_cnt++; if (val_a[0] !== 1'b0) begin err_cnt++; $display("FAIL reset_val: got %b want 0", val_a[0]); end
    cmp_cnt++; if (lvl_a[0] !== 8'd0) begin err_cnt++; $display("FAIL reset_level: got %0d want 0", lvl_a[0]); end
    cmp_cnt++; if (pop_a[0] !== 1'b0) begin err_cnt++; $display("FAIL reset_pop: got %b want 0", pop_a[0]); end
    $display("reset: checked");
  endtask

  task automatic test_stream();
    logic ev;
    apply_reset();
    load(0, 16, 0);
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      rst = 1'b0;
      rdy_a[0] = 1'b1;
      #1;
      ev = (c >= 4 && c < 20);
      cmp_cnt++; if (pop_a[0] !== (c < 16)) begin err_cnt++; $display("FAIL stream_pop c=%0d: got %b want %b", c, pop_a[0], (c < 16)); end
      cmp_cnt++; if (val_a[0] !== ev) begin err_cnt++; $display("FAIL stream_val c=%0d: got %b want %b", c, val_a[0], ev); end
      if (ev) begin
        cmp_cnt++; if (bus_a[0] !== 32'(c - 4)) begin err_cnt++; $display("FAIL stream_data c=%0d: got %0d want %0d", c, bus_a[0], c - 4); end
        $display("stream beat data %0d", bus_a[0]);
      end
      if (c == 0 || c == 10) begin
        cmp_cnt++; if (lvl_a[0] !== ((c == 0) ? 8'd0 : 8'd4)) begin err_cnt++; $display("FAIL stream_level c=%0d: got %0d want %0d", c, lvl_a[0], (c == 0) ? 0 : 4); end
      end
    end
  endtask

  task automatic test_stall();
    int n_out = 0;
    logic prev_hold = 1'b0;
    logic [31:0] prev_bus = '0;
    apply_reset();
    load(0, 20, 0);
    for (int c = 0; c < 46; c++) begin
      if (c > 0) @(negedge clk);
      rst = 1'b0;
      rdy_a[0] = !(c >= 8 && c < 18);
      #1;
      if (prev_hold) begin
        cmp_cnt++; if (val_a[0] !== 1'b1 || bus_a[0] !== prev_bus) begin err_cnt++; $display("FAIL stall_hold c=%0d: got val %b data %0d want val 1 data %0d", c, val_a[0], bus_a[0], prev_bus); end
      end
      if (c >= 4 && n_out < 20) begin
        cmp_cnt++; if (val_a[0] !== 1'b1) begin err_cnt++; $display("FAIL stall_gap c=%0d: got val %b want 1", c, val_a[0]); end
      end
      if (val_a[0] === 1'b1) begin
        cmp_cnt++; if (bus_a[0] !== 32'(n_out)) begin err_cnt++; $display("FAIL stall_order c=%0d: got %0d want %0d", c, bus_a[0], n_out); end
      end
      cmp_cnt++; if (lvl_a[0] > 8'd5) begin err_cnt++; $display("FAIL stall_level_max c=%0d: got %0d want <=5", c, lvl_a[0]); end
      if (c == 17) begin
        cmp_cnt++; if (lvl_a[0] !== 8'd5) begin err_cnt++; $display("FAIL stall_level_full: got %0d want 5", lvl_a[0]); end
        cmp_cnt++; if (pop_a[0] !== 1'b0) begin err_cnt++; $display("FAIL stall_pop_stop: got %b want 0", pop_a[0]); end
      end
      prev_hold = val_a[0] & ~rdy_a[0];
      prev_bus  = bus_a[0];
      if (val_a[0] === 1'b1 && rdy_a[0]) begin
        $display("stall beat data %0d", bus_a[0]);
        n_out++;
      end
    end
    cmp_cnt++; if (n_out != 20) begin err_cnt++; $display("FAIL stall_count: got %0d want 20", n_out); end
  endtask

  task automatic test_empty_edge();
    logic ev;
    apply_reset();
    load(0, 1, 0);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      rst = 1'b0;
      rdy_a[0] = 1'b1;
      if (c == 5) load(0, 1, 1);
      #1;
      ev = (c == 4 || c == 9);
      cmp_cnt++; if (pop_a[0] !== (c == 0 || c == 5)) begin err_cnt++; $display("FAIL empty_pop c=%0d: got %b want %b", c, pop_a[0], (c == 0 || c == 5)); end
      cmp_cnt++; if (pop_a[0] === 1'b1 && empty_a[0] === 1'b1) begin err_cnt++; $display("FAIL empty_spurious c=%0d: got pop 1 want 0", c); end
      cmp_cnt++; if (val_a[0] !== ev) begin err_cnt++; $display("FAIL empty_val c=%0d: got %b want %b", c, val_a[0], ev); end
      if (ev) begin
        cmp_cnt++; if (bus_a[0] !== ((c == 4) ? 32'd0 : 32'd1)) begin err_cnt++; $display("FAIL empty_data c=%0d: got %0d want %0d", c, bus_a[0], (c == 4) ? 0 : 1); end
        $display("empty_edge beat data %0d", bus_a[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ev;
    apply_reset();
    load(0, 30, 0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      rst = 1'b0;
      rdy_a[0] = (c < 6);
      #1;
      if (c == 7) begin
        cmp_cnt++; if (lvl_a[0] !== 8'd5) begin err_cnt++; $display("FAIL midrst_level_pre: got %0d want 5", lvl_a[0]); end
        cmp_cnt++; if (pop_a[0] !== 1'b0) begin err_cnt++; $display("FAIL midrst_pop_pre: got %b want 0", pop_a[0]); end
      end
    end
    @(negedge clk);
    rst = 1'b1;
    rdy_a[0] = 1'b1;
    #1;
    cmp_cnt++; if (pop_a[0] !== 1'b0) begin err_cnt++; $display("FAIL midrst_pop_gate: got %b want 0", pop_a[0]); end
    @(negedge clk);
    #1;
    cmp_cnt++; if (val_a[0] !== 1'b0) begin err_cnt++; $display("FAIL midrst_val: got %b want 0", val_a[0]); end
    cmp_cnt++; if (lvl_a[0] !== 8'd0) begin err_cnt++; $display("FAIL midrst_level: got %0d want 0", lvl_a[0]); end
    cmp_cnt++; if (pop_a[0] !== 1'b0) begin err_cnt++; $display("FAIL midrst_pop: got %b want 0", pop_a[0]); end
    wr_a[0] = 0;
    load(0, 4, 100);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      rst = 1'b0;
      #1;
      ev = (c >= 4 && c < 8);
      cmp_cnt++; if (val_a[0] !== ev) begin err_cnt++; $display("FAIL midrst_fresh_val c=%0d: got %b want %b", c, val_a[0], ev); end
      if (ev) begin
        cmp_cnt++; if (bus_a[0] !== 32'(96 + c)) begin err_cnt++; $display("FAIL midrst_fresh_data c=%0d: got %0d want %0d", c, bus_a[0], 96 + c); end
        $display("reset_mid beat data %0d", bus_a[0]);
      end
    end
  endtask

  // Shared loop shape for random and wrap scenarios is written out per task.
  task automatic test_random(input int i);
    int n_out = 0;
    int dmax;
    logic prev_hold = 1'b0;
    logic [31:0] prev_bus = '0;
    dmax = (i == 1) ? 3 : (i == 2) ? 4 : 7;
    apply_reset();
    load(i, 60, 0);
    for (int c = 0; c < 500; c++) begin
      if (c > 0) @(negedge clk);
      rst = 1'b0;
      rdy_a[i] = ($urandom_range(0, 1) == 1);
      gap_a[i] = ($urandom_range(0, 3) == 0);
      #1;
      cmp_cnt++; if (pop_a[i] === 1'b1 && empty_a[i] === 1'b1) begin err_cnt++; $display("FAIL rand%0d_spurious c=%0d: got pop 1 want 0", i, c); end
      if (prev_hold) begin
        cmp_cnt++; if (val_a[i] !== 1'b1 || bus_a[i] !== prev_bus) begin err_cnt++; $display("FAIL rand%0d_hold c=%0d: got val %b data %0d want val 1 data %0d", i, c, val_a[i], bus_a[i], prev_bus); end
      end
      if (val_a[i] === 1'b1) begin
        cmp_cnt++; if (bus_a[i] !== 32'(n_out)) begin err_cnt++; $display("FAIL rand%0d_order c=%0d: got %0d want %0d", i, c, bus_a[i], n_out); end
      end
      cmp_cnt++; if (lvl_a[i] > 8'(dmax)) begin err_cnt++; $display("FAIL rand%0d_level c=%0d: got %0d want <=%0d", i, c, lvl_a[i], dmax); end
      prev_hold = val_a[i] & ~rdy_a[i];
      prev_bus  = bus_a[i];
      if (val_a[i] === 1'b1 && rdy_a[i]) begin
        $display("rand%0d beat data %0d", i, bus_a[i]);
        n_out++;
      end
    end
    cmp_cnt++; if (n_out != 60) begin err_cnt++; $display("FAIL rand%0d_count: got %0d want 60", i, n_out); end
  endtask

  task automatic test_wrap();
    int n_out = 0;
    logic prev_hold = 1'b0;
    logic [31:0] prev_bus = '0;
    apply_reset();
    load(1, 100, 0);
    for (int c = 0; c < 260; c++) begin
      if (c > 0) @(negedge clk);
      rst = 1'b0;
      rdy_a[1] = (c % 2 == 1);
      #1;
      if (prev_hold) begin
        cmp_cnt++; if (val_a[1] !== 1'b1 || bus_a[1] !== prev_bus) begin err_cnt++; $display("FAIL wrap_hold c=%0d: got val %b data %0d want val 1 data %0d", c, val_a[1], bus_a[1], prev_bus); end
      end
      if (val_a[1] === 1'b1) begin
        cmp_cnt++; if (bus_a[1] !== 32'(n_out)) begin err_cnt++; $display("FAIL wrap_order c=%0d: got %0d want %0d", c, bus_a[1], n_out); end
      end
      cmp_cnt++; if (lvl_a[1] > 8'd3) begin err_cnt++; $display("FAIL wrap_level c=%0d: got %0d want <=3", c, lvl_a[1]); end
      prev_hold = val_a[1] & ~rdy_a[1];
      prev_bus  = bus_a[1];
      if (val_a[1] === 1'b1 && rdy_a[1]) begin
        $display("wrap beat data %0d", bus_a[1]);
        n_out++;
      end
    end
    cmp_cnt++; if (n_out != 100) begin err_cnt++; $display("FAIL wrap_count: got %0d want 100", n_out); end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      wr_a[i]  = 0;
      gap_a[i] = 1'b0;
      rdy_a[i] = 1'b1;
    end
    test_reset();
    test_stream();
    test_stall();
    test_empty_edge();
    test_reset_mid();
    test_random(1);
    test_random(2);
    test_random(3);
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
